// File: rtl/enemy_formation_if.sv
// Bundle of per-frame control, pixel query, bullet query and status signals of the
// alien formation controller. The game side drives through master, the formation is slave.
interface enemy_formation_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              frame_tick;
    logic              start;
    logic              delete_enemies;
    logic [9:0]        init_x;
    logic [9:0]        init_y;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              hit_valid;
    logic [9:0]        hit_x;
    logic [9:0]        hit_y;
    logic              hit_busy;
    logic              hit_ack;
    logic              hit_found;
    logic [7:0]        hit_index;
    logic              enemy_on;
    logic [ADDR_W-1:0] sprite_addr;
    logic [7:0]        alive_count;
    logic              all_dead;
    logic              landed;

    modport master (
        output frame_tick, start, delete_enemies, init_x, init_y, DrawX, DrawY,
        output hit_valid, hit_x, hit_y,
        input  hit_busy, hit_ack, hit_found, hit_index, enemy_on, sprite_addr,
        input  alive_count, all_dead, landed
    );

    modport slave (
        input  frame_tick, start, delete_enemies, init_x, init_y, DrawX, DrawY,
        input  hit_valid, hit_x, hit_y,
        output hit_busy, hit_ack, hit_found, hit_index, enemy_on, sprite_addr,
        output alive_count, all_dead, landed
    );
endinterface

// File: rtl/enemy_formation.sv
// Single controller for a ROWS x COLS alien grid: march FSM, alive mask, per-pixel
// sprite hit-test with ROM address, and a one-alien-per-cycle bullet collision scan.
module enemy_formation #(
    parameter int unsigned ROWS            = 3,
    parameter int unsigned COLS            = 6,
    parameter int unsigned SPR_W           = 32,
    parameter int unsigned SPR_H           = 32,
    parameter int unsigned PITCH_X         = 48,
    parameter int unsigned PITCH_Y         = 40,
    parameter int unsigned STEP_X          = 2,
    parameter int unsigned STEP_Y          = 8,
    parameter int unsigned X_MAX           = 639,
    parameter int unsigned Y_LAND          = 440,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned ADDR_W          = 12
) (
    input logic              Clk,
    input logic              Reset,
    enemy_formation_if.slave bus
);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TickW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [2:0] {
        StIdle, StMarch, StStep, StDescend, StCleared, StLanded
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        fx_q, fx_d, fy_q, fy_d;
    logic              dir_right_q, dir_right_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [N-1:0]      alive_q, alive_d;
    logic              busy_q, busy_d;
    logic [IdxW-1:0]   scan_idx_q, scan_idx_d;
    logic [9:0]        hx_q, hx_d, hy_q, hy_d, sfx_q, sfx_d, sfy_q, sfy_d;
    logic              ack_q, ack_d, found_q, found_d;
    logic [7:0]        index_q, index_d;
    logic              enemy_on_q, enemy_on_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic              all_dead_q, all_dead_d;

    logic              in_play, kill_all, scan_match, pix_hit;
    logic [9:0]        pix_rx, pix_ry;
    logic [COLS-1:0]   col_live;
    logic [ROWS-1:0]   row_live;
    int unsigned       left_off, right_ext, bottom_ext, scan_r, scan_c;

    // 10-bit offset test: a negative offset wraps to a large value and falls outside.
    function automatic logic alien_contains(input logic [9:0] px, input logic [9:0] py,
                                            input logic [9:0] ox, input logic [9:0] oy,
                                            input int unsigned r, input int unsigned c);
        logic [9:0] dx, dy;
        dx = px - ox - 10'(c * PITCH_X);
        dy = py - oy - 10'(r * PITCH_Y);
        return (32'(dx) < SPR_W) && (32'(dy) < SPR_H);
    endfunction

    assign in_play  = (state_q == StMarch) || (state_q == StStep) || (state_q == StDescend);
    assign kill_all = bus.delete_enemies && (state_q != StIdle);

    // Which rows and columns still hold at least one live alien.
    always_comb begin
        col_live = '0;
        row_live = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_q[r*COLS+c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
    end

    // Formation extents relative to the origin, from live columns/rows only.
    always_comb begin
        left_off   = 0;
        right_ext  = 0;
        bottom_ext = 0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_live[c]) left_off = c * PITCH_X;
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_live[c]) right_ext = c * PITCH_X + SPR_W - 1;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_live[r]) bottom_ext = r * PITCH_Y + SPR_H - 1;
        end
    end

    // Collision test of the alien currently addressed by the scan index.
    always_comb begin
        scan_r     = 32'(scan_idx_q) / COLS;
        scan_c     = 32'(scan_idx_q) % COLS;
        scan_match = alive_q[scan_idx_q] &&
                     alien_contains(hx_q, hy_q, sfx_q, sfy_q, scan_r, scan_c);
    end

    // Pixel hit-test; sprites never overlap, so the first live match is the only one.
    always_comb begin
        pix_hit = 1'b0;
        pix_rx  = '0;
        pix_ry  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!pix_hit && alive_q[r*COLS+c] &&
                    alien_contains(bus.DrawX, bus.DrawY, fx_q, fy_q, r, c)) begin
                    pix_hit = 1'b1;
                    pix_rx  = bus.DrawX - fx_q - 10'(c * PITCH_X);
                    pix_ry  = bus.DrawY - fy_q - 10'(r * PITCH_Y);
                end
            end
        end
        enemy_on_d = pix_hit && !kill_all;
        addr_d     = enemy_on_d ? ADDR_W'(32'(pix_ry) * SPR_W + 32'(pix_rx)) : '0;
    end

    // Live count and wave-cleared flag, registered so they trail a kill by one cycle.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < N; i++) begin
            count_d = count_d + 8'(alive_q[i]);
        end
        all_dead_d = (alive_q == '0);
    end

    // Next state: delete > start > scan kill > march.
    always_comb begin
        state_d     = state_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        dir_right_d = dir_right_q;
        tick_d      = tick_q;
        alive_d     = alive_q;
        busy_d      = busy_q;
        scan_idx_d  = scan_idx_q;
        hx_d        = hx_q;
        hy_d        = hy_q;
        sfx_d       = sfx_q;
        sfy_d       = sfy_q;
        ack_d       = 1'b0;
        found_d     = 1'b0;
        index_d     = index_q;
        if (kill_all) begin
            alive_d = '0;
            busy_d  = 1'b0;
            state_d = StCleared;
        end else if (bus.start) begin
            fx_d        = bus.init_x;
            fy_d        = bus.init_y;
            dir_right_d = 1'b1;
            tick_d      = '0;
            alive_d     = '1;
            busy_d      = 1'b0;
            state_d     = StMarch;
        end else begin
            if (busy_q) begin
                if (scan_match) begin
                    alive_d[scan_idx_q] = 1'b0;
                    ack_d               = 1'b1;
                    found_d             = 1'b1;
                    index_d             = 8'(scan_idx_q);
                    busy_d              = 1'b0;
                end else if (scan_idx_q == IdxW'(N - 1)) begin
                    ack_d  = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end else if (bus.hit_valid && in_play) begin
                // Origin is latched too, so a march step mid-scan cannot skew the test.
                hx_d       = bus.hit_x;
                hy_d       = bus.hit_y;
                sfx_d      = fx_q;
                sfy_d      = fy_q;
                scan_idx_d = '0;
                busy_d     = 1'b1;
            end
            if (in_play && alive_q == '0) begin
                state_d = StCleared;
            end else begin
                case (state_q)
                    StIdle: ;
                    StMarch: begin
                        if (bus.frame_tick) begin
                            if (tick_q == TickW'(FRAMES_PER_STEP - 1)) begin
                                tick_d  = '0;
                                state_d = StStep;
                            end else begin
                                tick_d = tick_q + 1'b1;
                            end
                        end
                    end
                    StStep: begin
                        if (dir_right_q ? (32'(fx_q) + right_ext + STEP_X > X_MAX)
                                        : (32'(fx_q) + left_off < STEP_X)) begin
                            state_d = StDescend;
                        end else begin
                            fx_d    = dir_right_q ? fx_q + 10'(STEP_X) : fx_q - 10'(STEP_X);
                            state_d = StMarch;
                        end
                    end
                    StDescend: begin
                        fy_d        = fy_q + 10'(STEP_Y);
                        dir_right_d = !dir_right_q;
                        state_d     = (32'(fy_d) + bottom_ext >= Y_LAND) ? StLanded : StMarch;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with synchronous reset; origin loads from init_x/init_y.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            fx_q        <= bus.init_x;
            fy_q        <= bus.init_y;
            dir_right_q <= 1'b1;
            tick_q      <= '0;
            alive_q     <= '1;
            busy_q      <= 1'b0;
            scan_idx_q  <= '0;
            hx_q        <= '0;
            hy_q        <= '0;
            sfx_q       <= '0;
            sfy_q       <= '0;
            ack_q       <= 1'b0;
            found_q     <= 1'b0;
            index_q     <= '0;
            enemy_on_q  <= 1'b0;
            addr_q      <= '0;
            count_q     <= 8'(N);
            all_dead_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            dir_right_q <= dir_right_d;
            tick_q      <= tick_d;
            alive_q     <= alive_d;
            busy_q      <= busy_d;
            scan_idx_q  <= scan_idx_d;
            hx_q        <= hx_d;
            hy_q        <= hy_d;
            sfx_q       <= sfx_d;
            sfy_q       <= sfy_d;
            ack_q       <= ack_d;
            found_q     <= found_d;
            index_q     <= index_d;
            enemy_on_q  <= enemy_on_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            all_dead_q  <= all_dead_d;
        end
    end

    assign bus.hit_busy    = busy_q;
    assign bus.hit_ack     = ack_q;
    assign bus.hit_found   = found_q;
    assign bus.hit_index   = index_q;
    assign bus.enemy_on    = enemy_on_q;
    assign bus.sprite_addr = addr_q;
    assign bus.alive_count = count_q;
    assign bus.all_dead    = all_dead_q;
    assign bus.landed      = (state_q == StLanded);
endmodule

// File: tb/tb_enemy_formation.sv
// Bench for enemy_formation: directed sequence plus randomized probes and shots, checked
// against a frame-level model of the march, alive mask, hit-test and scan latency.
module tb_enemy_formation;
    localparam int ROWS = 3, COLS = 6, N = 18;
    localparam int SW = 32, SH = 32, PX = 48, PY = 40;
    localparam int STX = 2, STY = 8, XMAX = 639, YLAND = 440, FPS = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    enemy_formation_if #(.ADDR_W(12)) bus ();

    enemy_formation #(
        .ROWS(ROWS), .COLS(COLS), .SPR_W(SW), .SPR_H(SH), .PITCH_X(PX), .PITCH_Y(PY),
        .STEP_X(STX), .STEP_Y(STY), .X_MAX(XMAX), .Y_LAND(YLAND), .FRAMES_PER_STEP(FPS),
        .ADDR_W(12)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_fx, m_fy, m_cnt;
    bit m_right, m_landed;
    bit m_alive[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic int live_total();
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(m_alive[i]);
        return n;
    endfunction

    function automatic void m_start(input int x, input int y);
        m_fx = x; m_fy = y; m_right = 1; m_cnt = 0; m_landed = 0;
        for (int i = 0; i < N; i++) m_alive[i] = 1;
    endfunction

    // One march step: wall test against the live bounding box, else slide sideways.
    function automatic void m_step();
        int lc = COLS, rc = -1, br = -1;
        for (int i = 0; i < N; i++) begin
            if (m_alive[i]) begin
                if (i % COLS < lc) lc = i % COLS;
                if (i % COLS > rc) rc = i % COLS;
                if (i / COLS > br) br = i / COLS;
            end
        end
        if (m_right ? (m_fx + rc * PX + SW - 1 + STX > XMAX) : (m_fx + lc * PX < STX)) begin
            m_fy += STY;
            m_right = !m_right;
            if (m_fy + br * PY + SH - 1 >= YLAND) m_landed = 1;
        end else begin
            m_fx += m_right ? STX : -STX;
        end
    endfunction

    function automatic void m_tick();
        if (m_landed || live_total() == 0) return;
        m_cnt++;
        if (m_cnt == FPS) begin
            m_cnt = 0;
            m_step();
        end
    endfunction

    function automatic bit m_contains(input int px, input int py, input int i);
        return (((px - m_fx - (i % COLS) * PX) & 1023) < SW) &&
               (((py - m_fy - (i / COLS) * PY) & 1023) < SH);
    endfunction

    function automatic int m_hit_idx(input int px, input int py);
        for (int i = 0; i < N; i++) if (m_alive[i] && m_contains(px, py, i)) return i;
        return -1;
    endfunction

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            bus.frame_tick = 1;
            cyc(1);
            bus.frame_tick = 0;
            cyc(3);
            m_tick();
        end
    endtask

    task automatic start_wave(input int x, input int y);
        bus.init_x = 10'(x);
        bus.init_y = 10'(y);
        bus.start  = 1;
        cyc(1);
        bus.start  = 0;
        cyc(1);
        m_start(x, y);
    endtask

    task automatic kill_everything();
        bus.delete_enemies = 1;
        cyc(1);
        bus.delete_enemies = 0;
        cyc(2);
        for (int i = 0; i < N; i++) m_alive[i] = 0;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_fx"}, 32'(dut.fx_q), m_fx);
        check({tag, "_fy"}, 32'(dut.fy_q), m_fy);
    endtask

    task automatic probe(input string tag, input int x, input int y);
        int idx, addr;
        bit on;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        cyc(1);
        idx  = m_hit_idx(x & 1023, y & 1023);
        on   = (idx >= 0);
        addr = on ? ((((y - m_fy - (idx / COLS) * PY) & 1023) * SW +
                      ((x - m_fx - (idx % COLS) * PX) & 1023)) & 4095) : 0;
        check({tag, "_on"}, 32'(bus.enemy_on), 32'(on));
        check({tag, "_addr"}, 32'(bus.sprite_addr), addr);
    endtask

    task automatic shoot(input string tag, input int x, input int y);
        int exp_idx, n;
        exp_idx     = m_hit_idx(x, y);
        bus.hit_x   = 10'(x);
        bus.hit_y   = 10'(y);
        bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        n = 0;
        while (bus.hit_busy === 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        check({tag, "_busy_len"}, n, (exp_idx < 0) ? N : exp_idx + 1);
        check({tag, "_ack"}, 32'(bus.hit_ack), 1);
        check({tag, "_found"}, 32'(bus.hit_found), 32'(exp_idx >= 0));
        if (exp_idx >= 0) begin
            check({tag, "_index"}, 32'(bus.hit_index), exp_idx);
            m_alive[exp_idx] = 0;
        end
        cyc(1);
        check({tag, "_count"}, 32'(bus.alive_count), live_total());
    endtask

    initial begin
        int acks, founds, ons, r, c;
        bus.frame_tick = 0; bus.start = 0; bus.delete_enemies = 0;
        bus.init_x = 10'd100; bus.init_y = 10'd50;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        bus.hit_valid = 0; bus.hit_x = 10'd0; bus.hit_y = 10'd0;
        Reset = 1;
        cyc(3);
        check("rst_enemy_on", 32'(bus.enemy_on), 0);
        check("rst_addr", 32'(bus.sprite_addr), 0);
        check("rst_busy", 32'(bus.hit_busy), 0);
        check("rst_ack", 32'(bus.hit_ack), 0);
        check("rst_found", 32'(bus.hit_found), 0);
        check("rst_index", 32'(bus.hit_index), 0);
        check("rst_landed", 32'(bus.landed), 0);
        check("rst_all_dead", 32'(bus.all_dead), 0);
        check("rst_count", 32'(bus.alive_count), N);
        Reset = 0;
        cyc(1);

        // Start and pixel path at the origin
        start_wave(100, 50);
        probe("pix_origin", 100, 50);
        probe("pix_corner", 131, 81);
        probe("pix_gap", 140, 50);
        for (int k = 0; k < 20; k++)
            probe("pix_rand", m_fx + int'($urandom_range(0, 300)) - 20,
                  m_fy + int'($urandom_range(0, 140)) - 10);

        frames(16);
        check_pos("march16");
        check("march16_count", 32'(bus.alive_count), N);

        // Bullet scan: kill, miss, and a request ignored while busy
        shoot("hit_150_60", 150, 60);
        shoot("miss_150_60", 150, 60);
        bus.hit_x = 10'd150; bus.hit_y = 10'd60; bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        cyc(2);
        bus.hit_x = 10'(m_fx + 5); bus.hit_y = 10'(m_fy + 5); bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        acks = 0; founds = 0;
        for (int k = 0; k < 45; k++) begin
            acks   += int'(bus.hit_ack === 1'b1);
            founds += int'(bus.hit_found === 1'b1);
            cyc(1);
        end
        check("busy_ignore_acks", acks, 1);
        check("busy_ignore_found", founds, 0);
        check("busy_ignore_count", 32'(bus.alive_count), live_total());

        // Full grid to the right wall and back
        kill_everything();
        start_wave(360, 50);
        for (int s = 0; s < 8; s++) begin
            frames(FPS);
            check_pos("wall_full");
        end

        // Column 5 gone: the wall arrives later
        kill_everything();
        start_wave(360, 50);
        for (int rr = 0; rr < ROWS; rr++) shoot("col5", m_fx + 5 * PX + 4, m_fy + rr * PY + 4);
        for (int s = 0; s < 30; s++) begin
            frames(FPS);
            check_pos("wall_col5");
        end

        // Randomized shots and probes interleaved with frames
        for (int k = 0; k < 12; k++) begin
            r = int'($urandom_range(0, ROWS - 1));
            c = int'($urandom_range(0, COLS - 1));
            shoot("rand_shot", m_fx + c * PX + int'($urandom_range(0, 40)) - 4,
                  m_fy + r * PY + int'($urandom_range(0, 40)) - 4);
            probe("rand_pix", m_fx + int'($urandom_range(0, 280)) - 10,
                  m_fy + int'($urandom_range(0, 120)) - 5);
            frames(int'($urandom_range(0, 3)));
        end
        check_pos("rand_end");

        // Clear every alien by shooting
        kill_everything();
        start_wave(100, 50);
        for (int i = 0; i < N; i++)
            shoot("clear", m_fx + (i % COLS) * PX + 3, m_fy + (i / COLS) * PY + 3);
        check("clear_all_dead", 32'(bus.all_dead), 1);
        check("clear_count", 32'(bus.alive_count), 0);
        frames(8);
        check_pos("clear_frozen");
        bus.hit_x = 10'd103; bus.hit_y = 10'd53; bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        check("clear_hit_ignored", 32'(bus.hit_busy), 0);
        ons = 0;
        for (int k = 0; k < 30; k++) begin
            bus.DrawX = 10'(m_fx + int'($urandom_range(0, 270)));
            bus.DrawY = 10'(m_fy + int'($urandom_range(0, 110)));
            cyc(1);
            ons += int'(bus.enemy_on === 1'b1);
        end
        check("clear_no_enemy_on", ons, 0);

        // delete_enemies during a scan aborts it without an ack
        start_wave(100, 50);
        bus.DrawX = 10'd110; bus.DrawY = 10'd60;
        bus.hit_x = 10'd600; bus.hit_y = 10'd400; bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        cyc(3);
        check("del_pre_enemy_on", 32'(bus.enemy_on), 1);
        bus.delete_enemies = 1;
        cyc(1);
        bus.delete_enemies = 0;
        check("del_busy", 32'(bus.hit_busy), 0);
        check("del_enemy_on", 32'(bus.enemy_on), 0);
        acks = 0;
        for (int k = 0; k < 30; k++) begin
            acks += int'(bus.hit_ack === 1'b1);
            cyc(1);
        end
        check("del_no_ack", acks, 0);
        check("del_count", 32'(bus.alive_count), 0);
        check("del_all_dead", 32'(bus.all_dead), 1);
        for (int i = 0; i < N; i++) m_alive[i] = 0;

        // Landing line: one pixel short, then exactly on it
        start_wave(360, 320);
        frames(20);
        check_pos("land_short");
        check("land_short_flag", 32'(bus.landed), 32'(m_landed));
        kill_everything();
        start_wave(360, 321);
        frames(20);
        check_pos("land_hit");
        check("land_hit_flag", 32'(bus.landed), 32'(m_landed));
        frames(8);
        check_pos("land_frozen");
        bus.hit_x = 10'd365; bus.hit_y = 10'd330; bus.hit_valid = 1;
        cyc(1);
        bus.hit_valid = 0;
        check("land_hit_ignored", 32'(bus.hit_busy), 0);

        // Reset in the middle of a march
        kill_everything();
        start_wave(100, 50);
        frames(6);
        shoot("pre_rst", m_fx + 3 * PX + 5, m_fy + 5);
        bus.DrawX = 10'(m_fx + 10); bus.DrawY = 10'(m_fy + 10);
        Reset = 1;
        cyc(2);
        check("rst2_enemy_on", 32'(bus.enemy_on), 0);
        check("rst2_addr", 32'(bus.sprite_addr), 0);
        check("rst2_index", 32'(bus.hit_index), 0);
        check("rst2_found", 32'(bus.hit_found), 0);
        check("rst2_busy", 32'(bus.hit_busy), 0);
        check("rst2_count", 32'(bus.alive_count), N);
        check("rst2_all_dead", 32'(bus.all_dead), 0);
        check("rst2_landed", 32'(bus.landed), 0);
        check("rst2_fx", 32'(dut.fx_q), 100);
        Reset = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enemy_formation.md
Name: enemy_formation

Overview:
- Parametrised grid of ROWS x COLS aliens that replaces per-alien sprite instances with one controller.
- Owns the formation origin, the per-alien alive mask, the classic march (sideways, descend at the wall, reverse), per-pixel sprite hit-test with ROM address output, and a sequential bullet-collision scan.
- Sits between the VGA DrawX/DrawY counters, the shared sprite ROM and the game-state FSM.

Parameters:
ROWS, 3, alien rows (1..8)
COLS, 6, alien columns (1..16)
SPR_W, 32, sprite width in pixels
SPR_H, 32, sprite height in pixels
PITCH_X, 48, horizontal origin-to-origin spacing (>= SPR_W)
PITCH_Y, 40, vertical origin-to-origin spacing (>= SPR_H)
STEP_X, 2, pixels per march step
STEP_Y, 8, pixels per descent
X_MAX, 639, rightmost legal pixel
Y_LAND, 440, landing line
FRAMES_PER_STEP, 4, frame ticks per march step
ADDR_W, 12, sprite ROM address width

Ports:
Clk  in  1  system clock
Reset  in  1  sync active-high reset
frame_tick  in  1  one-Clk pulse per frame (vblank start)
start  in  1  begin/restart the wave
delete_enemies  in  1  clear all aliens
init_x, init_y  in  10 each  formation origin loaded on start
DrawX, DrawY  in  10 each  current pixel
hit_valid  in  1  bullet-check request pulse
hit_x, hit_y  in  10 each  bullet tip position
hit_busy  out  1  collision scan in progress
hit_ack  out  1  one-cycle pulse at scan end
hit_found  out  1  valid with hit_ack: an alien was destroyed
hit_index  out  8  row*COLS+col of destroyed alien (valid with hit_found)
enemy_on  out  1  current pixel lies inside a live alien
sprite_addr  out  ADDR_W  sprite ROM address for current pixel
alive_count  out  8  live aliens
all_dead  out  1  wave cleared
landed  out  1  formation reached Y_LAND

Behaviour:
- Reset: state IDLE; alive mask all ones; origin = init_x/init_y; direction right; tick counter 0.
- Reset outputs: enemy_on=0, sprite_addr=0, hit_busy=0, hit_ack=0, hit_found=0, hit_index=0, landed=0, all_dead=0, alive_count=ROWS*COLS.
- FSM states:
  - IDLE -(start)-> MARCH.
  - MARCH: count frame_ticks. On the tick where count==FRAMES_PER_STEP-1, clear count and go to STEP.
  - STEP (1 cycle): with the right wall condition below, if moving right and fx+right_extent+STEP_X > X_MAX, or moving left and fx+left_offset < STEP_X -> DESCEND. Otherwise fx +/- STEP_X, back to MARCH.
  - DESCEND (1 cycle): fy += STEP_Y, direction flips. If fy+bottom_extent >= Y_LAND -> LANDED, else MARCH.
  - CLEARED, LANDED: frozen; start reloads the origin and the full alive mask -> MARCH.
- Extents are computed from live columns/rows only: left_offset = leftmost live col*PITCH_X; right_extent = rightmost live col*PITCH_X+SPR_W-1; bottom_extent = lowest live row*PITCH_Y+SPR_H-1.
- Pixel path, 1-cycle latency: DrawX/DrawY sampled at cycle n produce enemy_on/sprite_addr at n+1.
  - Pixel is inside alien (r,c) when 0 <= DrawX-(fx+c*PITCH_X) < SPR_W and likewise for Y with PITCH_Y/SPR_H, and alive[r][c] is set.
  - Subtraction is 10-bit; a negative result wraps and counts as outside.
  - sprite_addr = ry*SPR_W+rx, truncated to ADDR_W. Forced to 0 when enemy_on=0.
- Collision scan:
  - hit_valid is accepted only when hit_busy=0 and state is MARCH/STEP/DESCEND; otherwise it is ignored.
  - On accept, latch hit_x/hit_y and the origin, and set hit_busy.
  - Test one alien per cycle, index 0 upward, using the same containment rule as the pixel path.
  - First live match: clear its alive bit, then hit_ack=1, hit_found=1, hit_index=idx, hit_busy=0. No match after ROWS*COLS cycles: hit_ack=1, hit_found=0.
  - Worst-case latency is ROWS*COLS+1 cycles.
- alive_count and all_dead update the cycle after a kill. all_dead=1 forces CLEARED.
- delete_enemies, any state except IDLE: next cycle alive mask = 0, state CLEARED, any scan aborted with hit_ack=0, enemy_on=0.
- Priority, highest first: Reset > delete_enemies > start > scan kill > march.
- frame_tick coinciding with a kill: both take effect. Extents use the post-kill mask on the following STEP.

Test Plan:
- Reset, start with init (100,50), 16 frame_ticks -> fx=108, fy=50, state MARCH, alive_count=18.
- March to the wall with defaults: right_extent=271, so fx+273 > 639 at fx=368 -> next step fy+=8, direction left, fx unchanged.
- DrawX=100, DrawY=50 at origin (100,50) -> next cycle enemy_on=1, sprite_addr=0. DrawX=131, DrawY=81 -> sprite_addr=1023. DrawX=140 -> enemy_on=0 (gap).
- Bullet at (150,60): hit_busy for 2 cycles, hit_ack with hit_found=1, hit_index=1, alive_count=17. Repeat -> hit_found=0 after 18 cycles. A second hit_valid while busy is ignored.
- Kill all of column 5, march right -> the wall is hit 48 px later than with the full grid. Kill all 18 -> all_dead=1, state CLEARED, enemy_on never asserts.
- delete_enemies mid-scan -> no hit_ack, alive_count=0. Drive fy near Y_LAND -> landed=1 and the origin is frozen. Reset mid-march -> all outputs return to reset values.
